gemm_seq_ctrl: RTL

Loop sequencer for the GEMM accelerator.
- Launched by the one-cycle `start` pulse from the NICE instruction interface. Latches the GEMM dimensions and base addresses.
- Walks the output matrix row by row, fetching int8 operand words from memory over a single read port.
- Drives the MAC datapath with clear/enable strobes and hands each finished dot product to the quantise/write stage.
- Reports busy status back to the instruction interface via `state` and signals completion via `fin`.

---
 rtl/gemm_seq_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/gemm_seq_ctrl.sv
// GEMM loop sequencer: walks M x N outputs, fetching K/4 LHS/RHS word pairs each.
// Registered outputs, one read outstanding; stalls on mem_req_ready and out_ready.
module gemm_seq_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              nice_clk,
  input  logic              nice_rst,
  input  logic              start,
  input  logic [31:0]       lhs_rows,
  input  logic [31:0]       lhs_cols,
  input  logic [31:0]       rhs_cols,
  input  logic [ADDR_W-1:0] lhs_addr,
  input  logic [ADDR_W-1:0] rhs_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic [1:0]        state,
  output logic              fin,
  output logic              err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [31:0]       mac_lhs,
  output logic [31:0]       mac_rhs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr
);

  typedef enum logic [2:0] {
    IDLE, RD_LHS, WT_LHS, RD_RHS, WT_RHS, MAC, OUT, DONE
  } fsm_t;

  fsm_t              fsm;
  logic [CNT_W-1:0]  m_q, n_q, k_q, r_q, c_q, k_off;
  logic [ADDR_W-1:0] rhs_base, lhs_row_base, rhs_col_base, dst_ptr;
  logic [ADDR_W-1:0] k_ext;
  logic [CNT_W:0]    k_nxt, c_nxt, r_nxt;
  logic              bad_dims;

  assign k_ext = ADDR_W'(k_q);
  assign k_nxt = {1'b0, k_off} + (CNT_W+1)'(4);
  assign c_nxt = {1'b0, c_q} + (CNT_W+1)'(1);
  assign r_nxt = {1'b0, r_q} + (CNT_W+1)'(1);

  // Oversized dimensions are rejected along with the zero / misaligned cases.
  assign bad_dims = (lhs_rows == 32'd0) || (rhs_cols == 32'd0) || (lhs_cols == 32'd0) ||
                    (lhs_cols[1:0] != 2'b00) || ((lhs_rows >> CNT_W) != 32'd0) ||
                    ((lhs_cols >> CNT_W) != 32'd0) || ((rhs_cols >> CNT_W) != 32'd0);

  always_ff @(posedge nice_clk or posedge nice_rst) begin
    if (nice_rst) begin
      fsm           <= IDLE;
      state         <= 2'b00;
      fin           <= 1'b0;
      err           <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mac_clr       <= 1'b0;
      mac_en        <= 1'b0;
      mac_lhs       <= '0;
      mac_rhs       <= '0;
      out_valid     <= 1'b0;
      out_addr      <= '0;
      m_q           <= '0;
      n_q           <= '0;
      k_q           <= '0;
      r_q           <= '0;
      c_q           <= '0;
      k_off         <= '0;
      rhs_base      <= '0;
      lhs_row_base  <= '0;
      rhs_col_base  <= '0;
      dst_ptr       <= '0;
    end else begin
      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
      fin     <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            m_q          <= lhs_rows[CNT_W-1:0];
            k_q          <= lhs_cols[CNT_W-1:0];
            n_q          <= rhs_cols[CNT_W-1:0];
            r_q          <= '0;
            c_q          <= '0;
            k_off        <= '0;
            rhs_base     <= rhs_addr;
            lhs_row_base <= lhs_addr;
            rhs_col_base <= rhs_addr;
            dst_ptr      <= dst_addr;
            err          <= bad_dims;
            if (bad_dims) begin
              fsm   <= DONE;
              state <= 2'b11;
              fin   <= 1'b1;
            end else begin
              fsm           <= RD_LHS;
              state         <= 2'b01;
              mac_clr       <= 1'b1;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= lhs_addr;
            end
          end
        end
        RD_LHS: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            fsm           <= WT_LHS;
          end
        end
        WT_LHS: begin
          if (mem_rsp_valid) begin
            mac_lhs       <= mem_rsp_data;
            fsm           <= RD_RHS;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= rhs_col_base + ADDR_W'(k_off);
          end
        end
        RD_RHS: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            fsm           <= WT_RHS;
          end
        end
        WT_RHS: begin
          if (mem_rsp_valid) begin
            mac_rhs <= mem_rsp_data;
            mac_en  <= 1'b1;
            fsm     <= MAC;
          end
        end
        MAC: begin
          k_off <= k_nxt[CNT_W-1:0];
          if (k_nxt < {1'b0, k_q}) begin
            fsm           <= RD_LHS;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= lhs_row_base + ADDR_W'(k_nxt);
          end else begin
            fsm       <= OUT;
            state     <= 2'b10;
            out_valid <= 1'b1;
            out_addr  <= dst_ptr;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            dst_ptr   <= dst_ptr + ADDR_W'(1);
            k_off     <= '0;
            mac_clr   <= 1'b1;
            if (c_nxt < {1'b0, n_q}) begin
              c_q           <= c_nxt[CNT_W-1:0];
              rhs_col_base  <= rhs_col_base + k_ext;
              fsm           <= RD_LHS;
              state         <= 2'b01;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= lhs_row_base;
            end else if (r_nxt < {1'b0, m_q}) begin
              r_q           <= r_nxt[CNT_W-1:0];
              c_q           <= '0;
              lhs_row_base  <= lhs_row_base + k_ext;
              rhs_col_base  <= rhs_base;
              fsm           <= RD_LHS;
              state         <= 2'b01;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= lhs_row_base + k_ext;
            end else begin
              fsm   <= DONE;
              state <= 2'b11;
              fin   <= 1'b1;
            end
          end
        end
        DONE: begin
          fsm   <= IDLE;
          state <= 2'b00;
        end
        default: begin
          fsm   <= IDLE;
          state <= 2'b00;
        end
      endcase
    end
  end

endmodule
